bpred_table_ctrl: RTL and testbench

Controller that owns and sequences a table of 2-bit branch-prediction state machines, one per index. It serves in-order prediction requests from fetch and later in-order resolutions from execute. Resolutions are matched to outstanding predictions through a small tracking FIFO. The block also runs a post-reset table-initialisation sweep and keeps saturating hit/miss statistics. It sits between the fetch stage (requester) and branch resolution in execute.

---
 rtl/bpred_table_ctrl.sv | 153 +++++++++++++++
 tb/tb_bpred_table_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_table_ctrl.sv
// rtl/bpred_table_ctrl.sv - 2-bit branch-prediction table controller
// Fetch requests read the table in order; execute resolutions update it through a tracking FIFO.
module bpred_table_ctrl #(
    parameter int IDX_BITS = 4,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [IDX_BITS-1:0]      req_idx,
    output logic                     req_ready,
    output logic                     pred_valid,
    output logic                     pred_taken,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_mispred,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic                res_mispred_q, res_mispred_d;
    logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d;

    logic [1:0]          tbl_q [ENTRIES];
    logic [IDX_BITS-1:0] fifo_idx_q [DEPTH];
    logic                fifo_pred_q [DEPTH];

    logic                accept, apply, req_pred, head_pred;
    logic [IDX_BITS-1:0] head_idx;
    logic [1:0]          head_state, head_next;
    logic                tbl_we;
    logic [IDX_BITS-1:0] tbl_waddr;
    logic [1:0]          tbl_wdata;

    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pred_valid_d  = 1'b0;
        pred_taken_d  = pred_taken_q;
        res_mispred_d = 1'b0;
        hit_d         = hit_q;
        miss_d        = miss_q;
        tbl_we        = 1'b0;
        tbl_waddr     = init_ptr_q;
        tbl_wdata     = 2'd0;

        req_ready  = (state_q == S_RUN) && (count_q != FULL);
        accept     = req_valid && req_ready;
        apply      = res_valid && (state_q == S_RUN) && (count_q != '0);
        // States 0 and 1 predict taken, so the prediction is the inverted MSB.
        req_pred   = ~tbl_q[req_idx][1];
        head_idx   = fifo_idx_q[rd_ptr_q];
        head_pred  = fifo_pred_q[rd_ptr_q];
        head_state = tbl_q[head_idx];

        case ({res_taken, head_state})
            3'b1_00, 3'b1_01, 3'b1_10: head_next = 2'd0;
            3'b1_11:                   head_next = 2'd2;
            3'b0_00:                   head_next = 2'd1;
            default:                   head_next = 2'd3;
        endcase

        if (state_q == S_INIT) begin
            tbl_we     = 1'b1;
            init_ptr_d = init_ptr_q + 1'b1;
            if (init_ptr_q == '1) state_d = S_RUN;
        end else if (apply) begin
            tbl_we    = 1'b1;
            tbl_waddr = head_idx;
            tbl_wdata = head_next;
        end

        if (accept) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            pred_valid_d = 1'b1;
            pred_taken_d = req_pred;
        end

        if (apply) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head_pred == res_taken) begin
                if (hit_q != '1) hit_d = hit_q + 1'b1;
            end else begin
                res_mispred_d = 1'b1;
                if (miss_q != '1) miss_d = miss_q + 1'b1;
            end
        end

        case ({accept, apply})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            init_ptr_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            res_mispred_q <= 1'b0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            res_mispred_q <= res_mispred_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
        end
    end

    // Storage arrays need no reset: the INIT sweep and the FIFO pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
        if (accept) begin
            fifo_idx_q[wr_ptr_q]  <= req_idx;
            fifo_pred_q[wr_ptr_q] <= req_pred;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign res_mispred = res_mispred_q;
    assign outstanding = count_q;
    assign hit_cnt     = hit_q;
    assign miss_cnt    = miss_q;
endmodule

// File: tb/tb_bpred_table_ctrl.sv
// tb/tb_bpred_table_ctrl.sv - directed self-checking bench for bpred_table_ctrl
module tb_bpred_table_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_idx = 4'd0;
    logic       req_ready;
    logic       pred_valid, pred_taken;
    logic       res_valid = 1'b0;
    logic       res_taken = 1'b0;
    logic       res_mispred;
    logic [2:0] outstanding;
    logic [7:0] hit_cnt, miss_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    bpred_table_ctrl #(.IDX_BITS(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .res_mispred(res_mispred),
        .outstanding(outstanding), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %0d exp 0", req_ready); else pass_cnt++;
        total_cnt++; if (pred_valid !== 1'b0) $display("FAIL rst_pred_valid got %0d exp 0", pred_valid); else pass_cnt++;
        total_cnt++; if (res_mispred !== 1'b0) $display("FAIL rst_mispred got %0d exp 0", res_mispred); else pass_cnt++;
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            total_cnt++; if (req_ready !== (k == 16)) $display("FAIL init_ready edge %0d got %0d exp %0d", k, req_ready, (k == 16)); else pass_cnt++;
            total_cnt++; if (outstanding !== 3'd0 || hit_cnt !== 8'd0 || miss_cnt !== 8'd0)
                $display("FAIL init_idle edge %0d got occ=%0d hit=%0d miss=%0d exp 0/0/0", k, outstanding, hit_cnt, miss_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_state_walk();
        bit ep [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bit rt [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int s = 0; s < 5; s++) begin
            req_valid = 1'b1; req_idx = 4'd3;
            step();
            req_valid = 1'b0;
            total_cnt++; if (pred_valid !== 1'b1 || pred_taken !== ep[s])
                $display("FAIL walk_pred step %0d got v=%0d t=%0d exp v=1 t=%0d", s, pred_valid, pred_taken, ep[s]);
            else pass_cnt++;
            res_valid = 1'b1; res_taken = rt[s];
            step();
            res_valid = 1'b0;
            total_cnt++; if (res_mispred !== (ep[s] != rt[s]))
                $display("FAIL walk_mispred step %0d got %0d exp %0d", s, res_mispred, (ep[s] != rt[s]));
            else pass_cnt++;
            total_cnt++; if (pred_valid !== 1'b0) $display("FAIL walk_pred_drop step %0d got %0d exp 0", s, pred_valid); else pass_cnt++;
        end
        total_cnt++; if (hit_cnt !== 8'd1) $display("FAIL walk_hit got %0d exp 1", hit_cnt); else pass_cnt++;
        total_cnt++; if (miss_cnt !== 8'd4) $display("FAIL walk_miss got %0d exp 4", miss_cnt); else pass_cnt++;
    endtask

    task automatic test_fill();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_idx = 4'(i);
            step();
            total_cnt++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || outstanding !== 3'(i + 1))
                $display("FAIL fill_push %0d got v=%0d t=%0d occ=%0d exp 1/1/%0d", i, pred_valid, pred_taken, outstanding, i + 1);
            else pass_cnt++;
        end
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL fill_full_ready got %0d exp 0", req_ready); else pass_cnt++;
        req_idx = 4'd7;
        step();
        total_cnt++; if (outstanding !== 3'd4 || pred_valid !== 1'b0)
            $display("FAIL fill_fifth got occ=%0d v=%0d exp 4/0", outstanding, pred_valid);
        else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        req_valid = 1'b0; res_valid = 1'b0;
        total_cnt++; if (outstanding !== 3'd3 || pred_valid !== 1'b0)
            $display("FAIL fill_pop got occ=%0d v=%0d exp 3/0", outstanding, pred_valid);
        else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL fill_ready_back got %0d exp 1", req_ready); else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b1;
        step(); step(); step();
        res_valid = 1'b0;
        total_cnt++; if (outstanding !== 3'd0 || hit_cnt !== 8'd5 || miss_cnt !== 8'd4)
            $display("FAIL fill_drain got occ=%0d hit=%0d miss=%0d exp 0/5/4", outstanding, hit_cnt, miss_cnt);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        req_valid = 1'b1; req_idx = 4'd5;
        step();
        req_valid = 1'b0;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        total_cnt++; if (res_mispred !== 1'b1 || miss_cnt !== 8'd5)
            $display("FAIL coll_setup got mp=%0d miss=%0d exp 1/5", res_mispred, miss_cnt);
        else pass_cnt++;
        req_valid = 1'b1;
        step();
        total_cnt++; if (pred_taken !== 1'b1 || outstanding !== 3'd1)
            $display("FAIL coll_pending got t=%0d occ=%0d exp 1/1", pred_taken, outstanding);
        else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        req_valid = 1'b0; res_valid = 1'b0;
        total_cnt++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1)
            $display("FAIL coll_pre_update got v=%0d t=%0d exp 1/1", pred_valid, pred_taken);
        else pass_cnt++;
        total_cnt++; if (outstanding !== 3'd1 || res_mispred !== 1'b1 || miss_cnt !== 8'd6)
            $display("FAIL coll_same_edge got occ=%0d mp=%0d miss=%0d exp 1/1/6", outstanding, res_mispred, miss_cnt);
        else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        total_cnt++; if (pred_taken !== 1'b0 || miss_cnt !== 8'd7)
            $display("FAIL coll_new_state got t=%0d miss=%0d exp 0/7", pred_taken, miss_cnt);
        else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        total_cnt++; if (res_mispred !== 1'b0 || hit_cnt !== 8'd6 || outstanding !== 3'd0)
            $display("FAIL coll_final got mp=%0d hit=%0d occ=%0d exp 0/6/0", res_mispred, hit_cnt, outstanding);
        else pass_cnt++;
    endtask

    task automatic test_spurious();
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        total_cnt++; if (res_mispred !== 1'b0 || hit_cnt !== 8'd6 || miss_cnt !== 8'd7 || outstanding !== 3'd0)
            $display("FAIL spur_ignored got mp=%0d hit=%0d miss=%0d occ=%0d exp 0/6/7/0", res_mispred, hit_cnt, miss_cnt, outstanding);
        else pass_cnt++;
        req_valid = 1'b1; req_idx = 4'd5;
        step();
        req_valid = 1'b0;
        total_cnt++; if (pred_taken !== 1'b0) $display("FAIL spur_state_d got %0d exp 0", pred_taken); else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        total_cnt++; if (pred_taken !== 1'b0 || miss_cnt !== 8'd8)
            $display("FAIL spur_table_unchanged got t=%0d miss=%0d exp 0/8", pred_taken, miss_cnt);
        else pass_cnt++;
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        total_cnt++; if (hit_cnt !== 8'd7 || outstanding !== 3'd0)
            $display("FAIL spur_drain got hit=%0d occ=%0d exp 7/0", hit_cnt, outstanding);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        req_valid = 1'b1;
        req_idx = 4'd5; step();
        req_idx = 4'd3; step();
        req_idx = 4'd0; step();
        req_valid = 1'b0;
        total_cnt++; if (outstanding !== 3'd3 || pred_valid !== 1'b1)
            $display("FAIL mrst_pre got occ=%0d v=%0d exp 3/1", outstanding, pred_valid);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (outstanding !== 3'd0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL mrst_async got occ=%0d v=%0d t=%0d rdy=%0d exp 0/0/0/0", outstanding, pred_valid, pred_taken, req_ready);
        else pass_cnt++;
        total_cnt++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || res_mispred !== 1'b0)
            $display("FAIL mrst_stats got hit=%0d miss=%0d mp=%0d exp 0/0/0", hit_cnt, miss_cnt, res_mispred);
        else pass_cnt++;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            total_cnt++; if (req_ready !== (k == 16)) $display("FAIL mrst_init edge %0d got %0d exp %0d", k, req_ready, (k == 16)); else pass_cnt++;
        end
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_idx = 4'(i);
            step();
            req_valid = 1'b0;
            total_cnt++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1)
                $display("FAIL mrst_entry %0d got v=%0d t=%0d exp 1/1", i, pred_valid, pred_taken);
            else pass_cnt++;
            res_valid = 1'b1; res_taken = 1'b1;
            step();
            res_valid = 1'b0;
        end
        total_cnt++; if (hit_cnt !== 8'd16 || miss_cnt !== 8'd0)
            $display("FAIL mrst_counts got hit=%0d miss=%0d exp 16/0", hit_cnt, miss_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_state_walk();
        test_fill();
        test_collision();
        test_spurious();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
